dct_sequencer: RTL and testbench
================================

# dct_sequencer

Upstream driver for the Avalon DCT slave (`avalon_dct`). It accepts a frame of fixed-point samples on a valid/ready stream and buffers the whole frame. It then programs the DCT slave over its Avalon-MM port and bursts the samples into it. Finally it reads back every coefficient and forwards each one on an output valid/ready stream.

## Interface
- NBITS, 16, sample/coefficient width (signed fixed point)
- MAX_LOG2, 5, largest supported frame is 2^MAX_LOG2 samples; sets the internal buffer depth
- Clock  in  1  sole clock, rising edge
- ResetN  in  1  synchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- cfg_m  in  8  integer bits M of the fixed-point format; latched on start
- cfg_log2n  in  4  log2 of frame size; latched on start; values > MAX_LOG2 saturate to MAX_LOG2
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the last coefficient handshakes
- in_data  in  NBITS  sample
- in_valid  in  1  sample valid
- in_ready  out  1  sequencer accepts a sample
- out_data  out  NBITS  coefficient
- out_index  out  8  coefficient index k
- out_last  out  1  k is the last index (2^L-1)
- out_valid  out  1  coefficient valid
- out_ready  in  1  consumer accepts
- dct_address  out  8  Avalon address to DCT slave
- dct_read  out  1  Avalon read
- dct_write  out  1  Avalon write
- dct_writedata  out  NBITS  Avalon write data
- dct_readdata  in  NBITS  Avalon read data
- dct_done  in  1  DCT slave: read data valid this cycle

## Operation
- DCT slave map: write addr 2 = M; write addr 0 = log2 size; writes to addr 1 = samples, in order, on consecutive cycles, no gaps. Read addr k = coefficient k; hold read and address until dct_done is high, then readdata is valid in that same cycle.
- L = latched, saturated cfg_log2n; N = 2^L (L=0 gives N=1).
- States:
  - IDLE: start=1 latches cfg, goes to CFG_M.
  - CFG_M: dct_write=1, addr 2, data = M (zero-extended). Goes to CFG_N.
  - CFG_N: dct_write=1, addr 0, data = L. Goes to FILL.
  - FILL: in_ready=1. Each in_valid&in_ready stores in_data at buffer[cnt], cnt++. After the N-th accept, goes to BURST, cnt=0.
  - BURST: dct_write=1, addr 1, data = buffer[cnt], cnt++ every cycle. Exactly N consecutive cycles, then READ with k=0.
  - READ: dct_read=1, addr k. When dct_done=1: capture dct_readdata into out_data, set out_index=k, go to OUT.
  - OUT: out_valid=1, dct_read=0. On out_ready: if k=N-1, pulse frame_done and go to IDLE; else k++ and go to READ.
- Outputs are registered.
- in_ready=0 outside FILL.
- dct_read and dct_write are never high together.
- dct_address=0 and dct_writedata=0 whenever both are low.
- The buffer holds 2^MAX_LOG2 entries of NBITS. Only entries 0..N-1 are used.
- dct_done outside READ is ignored.

## Timing
- Reset values (ResetN=0 at a rising edge): state IDLE, busy 0, frame_done 0, in_ready 0, out_valid 0, out_data 0, out_index 0, out_last 0, dct_read 0, dct_write 0, dct_address 0, dct_writedata 0, counters 0. Buffer contents are don't-care.
- Reset mid-frame aborts immediately with no further DCT bus activity. Partial frames are discarded.
- Frame timeline, with start high at edge 0:
  - CFG_M write visible in cycle 1.
  - CFG_N write in cycle 2.
  - in_ready high from cycle 3.
  - BURST begins the cycle after the N-th accept and lasts exactly N cycles.
  - dct_read rises the cycle after the last burst write.
- Per coefficient: dct_done at edge t puts out_valid high from t+1. A handshake at edge u puts dct_read high again from u+1 (for k<N-1).
- Minimum output throughput is one coefficient per 3 cycles when dct_done and out_ready are immediate.
- start while busy is ignored. start held high on the frame_done cycle is not seen; a new frame needs start in IDLE.
- out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0.

## Test plan
- Reset: hold ResetN=0 3 cycles with start=1 and in_valid=1 -> all outputs 0 and in_ready 0 throughout.
- Config: start with cfg_m=6, cfg_log2n=5 -> cycle 1 write addr 2 data 6; cycle 2 write addr 0 data 5; then 32 samples 8·cos(πi/32) in Q6.9 accepted; then 32 back-to-back writes at addr 1 in input order.
- Readback with a DCT model (dct_done 2 cycles after read) and out_ready=1 -> indices 0..31 in order, out_last only on 31, frame_done pulse once, busy drops after it.
- Backpressure: out_ready low 5 cycles on k=3 -> out_data/out_index held, dct_read stays 0, no skipped or repeated index; in_valid gaps during FILL -> BURST stays gapless.
- Saturation and edge sizes: cfg_log2n=9 with MAX_LOG2=5 -> addr-0 write of 5 and 32 samples; cfg_log2n=0 -> 1 sample, 1 coefficient, out_last=1.
- Reset mid-BURST at sample 10 -> next cycle dct_write=0 and IDLE; a following frame runs correctly.

Source files
------------

// File: rtl/dct_sequencer.sv
// dct_sequencer
// Buffers one frame of signed fixed-point samples from an input stream,
// programs an Avalon-MM DCT slave (M at addr 2, log2 size at addr 0),
// bursts the samples into addr 1 on consecutive cycles, then reads every
// coefficient back and forwards it on an output stream.
//
// Ports
//   Clock, ResetN           : clock (rising edge), synchronous active-low reset
//   start, cfg_m, cfg_log2n : frame request and format; sampled in IDLE only
//   busy, frame_done        : status; frame_done pulses after the last output
//   in_data/in_valid/in_ready                  : sample stream (sink)
//   out_data/out_index/out_last/out_valid/out_ready : coefficient stream
//   dct_address/dct_read/dct_write/dct_writedata/dct_readdata/dct_done
//                           : Avalon-MM master towards the DCT slave
//   dbg_state_o             : current FSM state encoding for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its data stable until that edge; ready
// may be driven independently of valid.
//
// All outputs are registered: the combinational block computes the value
// each output takes in the next state, and the flops present it.
module dct_sequencer #(
  parameter int NBITS    = 16,
  parameter int MAX_LOG2 = 5
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             start,
  input  logic [7:0]       cfg_m,
  input  logic [3:0]       cfg_log2n,
  output logic             busy,
  output logic             frame_done,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NBITS-1:0] out_data,
  output logic [7:0]       out_index,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       dct_address,
  output logic             dct_read,
  output logic             dct_write,
  output logic [NBITS-1:0] dct_writedata,
  input  logic [NBITS-1:0] dct_readdata,
  input  logic             dct_done,
  output logic [2:0]       dbg_state_o
);

  // Counters must reach N = 2^MAX_LOG2 itself, hence one extra bit.
  localparam int          CW    = MAX_LOG2 + 1;
  localparam int          DEPTH = 1 << MAX_LOG2;
  localparam logic [3:0]  MAX_L = 4'(MAX_LOG2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG_M = 3'd1,
    CFG_N = 3'd2,
    FILL  = 3'd3,
    BURST = 3'd4,
    READ  = 3'd5,
    OUT   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     k_q, k_d;
  logic [7:0]        m_q, m_d;
  logic [3:0]        l_q, l_d;

  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              in_ready_q, in_ready_d;
  logic [NBITS-1:0]  out_data_q, out_data_d;
  logic [7:0]        out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        dct_address_q, dct_address_d;
  logic              dct_read_q, dct_read_d;
  logic              dct_write_q, dct_write_d;
  logic [NBITS-1:0]  dct_writedata_q, dct_writedata_d;

  logic [NBITS-1:0]  mem_q [DEPTH];

  logic [CW-1:0]     n_val;
  logic [CW-1:0]     n_m1;
  logic [3:0]        l_sat;
  logic              accept;

  assign n_val  = CW'(1) << l_q;
  assign n_m1   = n_val - CW'(1);
  assign l_sat  = (cfg_log2n > MAX_L) ? MAX_L : cfg_log2n;
  assign accept = in_ready_q & in_valid;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    k_d             = k_q;
    m_d             = m_q;
    l_d             = l_q;
    frame_done_d    = 1'b0;
    out_valid_d     = 1'b0;
    out_data_d      = out_data_q;
    out_index_d     = out_index_q;
    out_last_d      = out_last_q;
    dct_read_d      = 1'b0;
    dct_write_d     = 1'b0;
    dct_address_d   = 8'd0;
    dct_writedata_d = '0;

    case (state_q)
      IDLE: begin
        // frame_done_q marks the cycle right after a frame ends; a start
        // still held from that frame must not launch a new one.
        if (start && !frame_done_q) begin
          m_d             = cfg_m;
          l_d             = l_sat;
          state_d         = CFG_M;
          dct_write_d     = 1'b1;
          dct_address_d   = 8'd2;
          dct_writedata_d = NBITS'(cfg_m);
        end
      end
      CFG_M: begin
        state_d         = CFG_N;
        dct_write_d     = 1'b1;
        dct_address_d   = 8'd0;
        dct_writedata_d = NBITS'(l_q);
      end
      CFG_N: begin
        state_d = FILL;
        cnt_d   = '0;
      end
      FILL: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == n_m1) begin
            // The first burst word is presented together with the state
            // change. For a one-sample frame that word is the sample being
            // accepted right now, so it bypasses the buffer.
            state_d         = BURST;
            cnt_d           = CW'(1);
            dct_write_d     = 1'b1;
            dct_address_d   = 8'd1;
            dct_writedata_d = (l_q == 4'd0) ? in_data : mem_q[0];
          end
        end
      end
      BURST: begin
        // cnt_q is the index of the next word to present.
        if (cnt_q == n_val) begin
          state_d       = READ;
          k_d           = '0;
          dct_read_d    = 1'b1;
          dct_address_d = 8'd0;
        end else begin
          dct_write_d     = 1'b1;
          dct_address_d   = 8'd1;
          dct_writedata_d = mem_q[cnt_q[MAX_LOG2-1:0]];
          cnt_d           = cnt_q + CW'(1);
        end
      end
      READ: begin
        if (dct_done) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_data_d  = dct_readdata;
          out_index_d = 8'(k_q);
          out_last_d  = (k_q == n_m1);
        end else begin
          dct_read_d    = 1'b1;
          dct_address_d = 8'(k_q);
        end
      end
      OUT: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (k_q == n_m1) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            k_d           = k_q + CW'(1);
            state_d       = READ;
            dct_read_d    = 1'b1;
            dct_address_d = 8'(k_q + CW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      k_q             <= '0;
      m_q             <= 8'd0;
      l_q             <= 4'd0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      in_ready_q      <= 1'b0;
      out_data_q      <= '0;
      out_index_q     <= 8'd0;
      out_last_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      dct_address_q   <= 8'd0;
      dct_read_q      <= 1'b0;
      dct_write_q     <= 1'b0;
      dct_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      k_q             <= k_d;
      m_q             <= m_d;
      l_q             <= l_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      in_ready_q      <= in_ready_d;
      out_data_q      <= out_data_d;
      out_index_q     <= out_index_d;
      out_last_q      <= out_last_d;
      out_valid_q     <= out_valid_d;
      dct_address_q   <= dct_address_d;
      dct_read_q      <= dct_read_d;
      dct_write_q     <= dct_write_d;
      dct_writedata_q <= dct_writedata_d;
    end
  end

  // Sample buffer: contents are don't-care after reset, so no reset here.
  always_ff @(posedge Clock) begin
    if (ResetN && accept) begin
      mem_q[cnt_q[MAX_LOG2-1:0]] <= in_data;
    end
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign in_ready      = in_ready_q;
  assign out_data      = out_data_q;
  assign out_index     = out_index_q;
  assign out_last      = out_last_q;
  assign out_valid     = out_valid_q;
  assign dct_address   = dct_address_q;
  assign dct_read      = dct_read_q;
  assign dct_write     = dct_write_q;
  assign dct_writedata = dct_writedata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dct_sequencer.sv
module tb_dct_sequencer;
  localparam int NBITS    = 16;
  localparam int MAX_LOG2 = 5;

  logic              Clock = 1'b0;
  logic              ResetN = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        cfg_m = 8'd0;
  logic [3:0]        cfg_log2n = 4'd0;
  logic              busy, frame_done;
  logic [NBITS-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NBITS-1:0]  out_data;
  logic [7:0]        out_index;
  logic              out_last, out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        dct_address;
  logic              dct_read, dct_write;
  logic [NBITS-1:0]  dct_writedata;
  logic [NBITS-1:0]  dct_readdata = '0;
  logic              dct_done = 1'b0;
  logic [2:0]        dbg_state_o;

  dct_sequencer #(.NBITS(NBITS), .MAX_LOG2(MAX_LOG2)) dut (
    .Clock(Clock), .ResetN(ResetN), .start(start), .cfg_m(cfg_m),
    .cfg_log2n(cfg_log2n), .busy(busy), .frame_done(frame_done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .dct_address(dct_address), .dct_read(dct_read), .dct_write(dct_write),
    .dct_writedata(dct_writedata), .dct_readdata(dct_readdata),
    .dct_done(dct_done), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [23:0] exp_wr_q[$];   // {addr, data} expected on the DCT write bus
  logic [24:0] exp_q[$];      // {index, last, data} expected on the output stream
  logic [15:0] smp_q[$];      // samples still to be offered on the input stream
  logic [15:0] frame_x[32];

  // DCT slave model memory (filled from the bus writes it sees)
  logic [15:0] sl_x[32];
  int          sl_n;
  logic [7:0]  sl_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in transform of the slave: any fixed function of (k, x[k], M)
  // exposes ordering, addressing and capture errors.
  function automatic logic [15:0] dct_fn(input int k, input logic [15:0] x, input logic [7:0] m);
    return x ^ 16'(k * 37 + int'(m));
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  // ---------------- one frame ----------------
  task automatic run_frame(input logic [7:0] m, input logic [3:0] log2n, input int lat,
                           input bit bp, input bit gaps, input bit rnd_ready, input int abort_at);
    int l, n, start_cyc, wr_idx, acc, n_fd, budget, rd_cnt, bp_cnt;
    int first_smp_cyc, last_acc_cyc, read_exp_cyc, done_cyc, fd_exp_cyc;
    bit prev_hold, prev_valid, finished;
    logic [15:0] h_data;
    logic [7:0]  h_idx;
    logic        h_last;
    logic [23:0] e;
    logic [24:0] eo;

    l = (int'(log2n) > MAX_LOG2) ? MAX_LOG2 : int'(log2n);
    n = 1 << l;
    exp_wr_q.delete(); exp_q.delete(); smp_q.delete();
    exp_wr_q.push_back({8'd2, 16'(m)});
    exp_wr_q.push_back({8'd0, 16'(l)});
    for (int i = 0; i < n; i++) begin
      smp_q.push_back(frame_x[i]);
      exp_wr_q.push_back({8'd1, frame_x[i]});
      exp_q.push_back({8'(i), (i == n - 1), dct_fn(i, frame_x[i], m)});
    end
    sl_n = 0; sl_m = 8'd0;
    wr_idx = 0; acc = 0; n_fd = 0; rd_cnt = 0; bp_cnt = 0;
    first_smp_cyc = -1; last_acc_cyc = -1; read_exp_cyc = -1; done_cyc = -1; fd_exp_cyc = -1;
    prev_hold = 0; prev_valid = 0; finished = 0;

    cfg_m = m; cfg_log2n = log2n; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    start_cyc = cyc;

    for (budget = 0; budget < 4000 && !finished; budget++) begin
      tick();
      // start stays high and cfg keeps changing: both must be ignored mid-frame
      cfg_m = 8'($urandom); cfg_log2n = 4'($urandom);

      check("rw_exclusive", 32'(dct_read & dct_write), 32'd0);
      if (!dct_read && !dct_write) begin
        check("addr_idle", 32'(dct_address), 32'd0);
        check("wdata_idle", 32'(dct_writedata), 32'd0);
      end
      if (!busy || dct_write || dct_read || out_valid) check("in_ready_off", 32'(in_ready), 32'd0);
      if (cyc == start_cyc + 3) check("in_ready_cycle3", 32'(in_ready), 32'd1);
      check("busy_in_frame", 32'(busy), frame_done ? 32'd0 : 32'd1);

      // DCT write bus
      if (dct_write) begin
        if (exp_wr_q.size() == 0) check("write_extra", 32'd1, 32'd0);
        else begin
          e = exp_wr_q.pop_front();
          check("write_addr", 32'(dct_address), 32'(e[23:16]));
          check("write_data", 32'(dct_writedata), 32'(e[15:0]));
        end
        if (dct_address == 8'd2) sl_m = dct_writedata[7:0];
        if (dct_address == 8'd1) begin sl_x[sl_n % 32] = dct_writedata; sl_n++; end
        if (wr_idx == 0) check("cfg_m_cycle", 32'(cyc), 32'(start_cyc + 1));
        if (wr_idx == 1) check("cfg_n_cycle", 32'(cyc), 32'(start_cyc + 2));
        if (wr_idx == 2) begin
          first_smp_cyc = cyc;
          check("burst_start", 32'(cyc), 32'(last_acc_cyc + 1));
        end
        if (wr_idx > 2) check("burst_gapless", 32'(cyc), 32'(first_smp_cyc + wr_idx - 2));
        wr_idx++;
        if (wr_idx == n + 2) read_exp_cyc = cyc + 1;
        if (abort_at >= 0 && wr_idx == abort_at + 3) begin
          ResetN = 1'b0; start = 1'b0; in_valid = 1'b0; dct_done = 1'b0; out_ready = 1'b0;
          tick();
          check("abort_write", 32'(dct_write), 32'd0);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_state", 32'(dbg_state_o), 32'd0);
          ResetN = 1'b1;
          return;
        end
      end

      // DCT slave: reads complete after 'lat' extra cycles; stray dct_done otherwise
      dct_done = 1'b0;
      dct_readdata = 16'($urandom);
      if (dct_read) begin
        if (rd_cnt == 0) check("read_start", 32'(cyc), 32'(read_exp_cyc));
        rd_cnt++;
        if (rd_cnt == lat + 1) begin
          dct_done = 1'b1;
          dct_readdata = dct_fn(int'(dct_address), sl_x[dct_address[4:0]], sl_m);
          done_cyc = cyc;
        end
      end else begin
        rd_cnt = 0;
        dct_done = 1'($urandom_range(0, 3) == 0);
      end

      // output stream consumer
      if (out_valid && !prev_valid) check("valid_after_done", 32'(cyc), 32'(done_cyc + 1));
      if (out_valid && prev_hold) begin
        check("hold_data", 32'(out_data), 32'(h_data));
        check("hold_index", 32'(out_index), 32'(h_idx));
        check("hold_last", 32'(out_last), 32'(h_last));
        check("hold_no_read", 32'(dct_read), 32'd0);
      end
      if (bp && out_valid && out_index == 8'd3 && bp_cnt < 5) begin
        out_ready = 1'b0;
        bp_cnt++;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      prev_hold = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("output_extra", 32'd1, 32'd0);
        else begin
          eo = exp_q.pop_front();
          check("out_index", 32'(out_index), 32'(eo[24:17]));
          check("out_last", 32'(out_last), 32'(eo[16]));
          check("out_data", 32'(out_data), 32'(eo[15:0]));
          if (eo[16]) fd_exp_cyc = cyc + 1;
          else read_exp_cyc = cyc + 1;
        end
      end else if (out_valid) begin
        prev_hold = 1; h_data = out_data; h_idx = out_index; h_last = out_last;
      end
      prev_valid = out_valid;

      if (frame_done) begin
        n_fd++;
        check("frame_done_cycle", 32'(cyc), 32'(fd_exp_cyc));
        finished = 1;
      end

      // input stream producer
      in_valid = (smp_q.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
      in_data  = in_valid ? smp_q[0] : 16'($urandom);
      if (in_valid && in_ready) begin
        void'(smp_q.pop_front());
        acc++;
        if (acc == n) last_acc_cyc = cyc;
      end
    end

    if (!finished) check("frame_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
    dct_done = 1'b0;
    // start is still high during the frame_done cycle and must not relaunch
    tick();
    check("no_restart", 32'(busy), 32'd0);
    check("frame_done_pulse", 32'(frame_done), 32'd0);
    check("write_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("output_queue_empty", 32'(exp_q.size()), 32'd0);
    check("frame_done_count", 32'(n_fd), 32'd1);
    start = 1'b0;
  endtask

  task automatic rand_samples();
    for (int i = 0; i < 32; i++) frame_x[i] = 16'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // reset with start and in_valid asserted
    ResetN = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_dct_read", 32'(dct_read), 32'd0);
      check("rst_dct_write", 32'(dct_write), 32'd0);
      check("rst_dct_address", 32'(dct_address), 32'd0);
      check("rst_dct_writedata", 32'(dct_writedata), 32'd0);
      check("rst_state", 32'(dbg_state_o), 32'd0);
    end
    ResetN = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // cosine frame in Q6.9, output backpressure on k=3
    for (int i = 0; i < 32; i++)
      frame_x[i] = 16'($rtoi(4096.0 * $cos(3.14159265358979 * i / 32.0)));
    run_frame(8'd6, 4'd5, 2, 1'b1, 1'b0, 1'b0, -1);

    // saturating size, input gaps, random output readiness
    rand_samples();
    run_frame(8'd3, 4'd9, 2, 1'b0, 1'b1, 1'b1, -1);

    // single-sample frame
    rand_samples();
    run_frame(8'd1, 4'd0, 1, 1'b0, 1'b0, 1'b0, -1);

    // reset during the burst at sample 10, then a clean frame
    rand_samples();
    run_frame(8'd6, 4'd5, 2, 1'b0, 1'b1, 1'b0, 10);
    rand_samples();
    run_frame(8'($urandom), 4'd4, 0, 1'b1, 1'b1, 1'b1, -1);

    // randomized frames
    for (int f = 0; f < 5; f++) begin
      rand_samples();
      run_frame(8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
